sseg_serial_driver: RTL and testbench

- Parametrised serial driver for N-digit seven-segment displays behind an external shift-register chain.
- Builds an 8*NUM_DIGITS segment vector, either hex-decoded text with blink and decimal points, or a raw bitmap.
- Snapshots the vector on a start request and shifts it out MSB-first with a generated serial clock, latch/enable and clear.
- Reports progress through a busy/done handshake.

---
 rtl/sseg_serial_driver_pkg.sv | 29 ++
 rtl/sseg_serial_driver_hex_decode.sv | 13 +
 rtl/sseg_serial_driver.sv | 178 +++++++++++++++++
 tb/tb_sseg_serial_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_serial_driver_pkg.sv
// Shared definitions for the seven-segment serial driver: FSM states,
// segment bit positions and the active-low hex-to-segment table.
package sseg_serial_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned SEG_BIT_A  = 0;
  localparam int unsigned SEG_BIT_B  = 1;
  localparam int unsigned SEG_BIT_C  = 2;
  localparam int unsigned SEG_BIT_D  = 3;
  localparam int unsigned SEG_BIT_E  = 4;
  localparam int unsigned SEG_BIT_F  = 5;
  localparam int unsigned SEG_BIT_G  = 6;
  localparam int unsigned SEG_BIT_DP = 7;

  // {g,f,e,d,c,b,a}, active-low; the decimal point is carried separately.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sseg_serial_driver_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module sseg_hex_decode
  import sseg_serial_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/sseg_serial_driver.sv
// Serial driver for an N-digit seven-segment display behind a shift-register
// chain: builds the segment vector, snapshots it and shifts it out MSB-first.
module sseg_serial_driver
  import sseg_serial_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [4*NUM_DIGITS-1:0]   hexs,
  input  logic [NUM_DIGITS-1:0]     points,
  input  logic [NUM_DIGITS-1:0]     les,
  input  logic [8*NUM_DIGITS-1:0]   raw_map,
  output logic                      seg_clk,
  output logic                      seg_sout,
  output logic                      seg_pen,
  output logic                      seg_clrn,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned VEC_W = 8 * NUM_DIGITS;
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W = $clog2(VEC_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(VEC_W - 1);

  state_e                state_q, state_d;
  logic [VEC_W-1:0]      sr_q, sr_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  seg_clk_q, seg_clk_d;
  logic                  seg_sout_q, seg_sout_d;
  logic                  seg_pen_q, seg_pen_d;
  logic                  clrn_q, clrn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [6:0]            seg7 [NUM_DIGITS];
  logic [VEC_W-1:0]      text_vec;
  logic [VEC_W-1:0]      seg_vec;
  logic [DIV_W-1:0]      div_inc;
  logic                  blink_phase;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    sseg_hex_decode u_dec (
      .hex   (hexs[4*g +: 4]),
      .seg_n (seg7[g])
    );
  end

  assign blink_phase = blink_q[BLINK_BITS-1];

  always_comb begin
    logic [7:0] digit_byte;
    text_vec = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit_byte = SEG_BLANK;
      if (!(les[i] && blink_phase)) begin
        digit_byte[SEG_BIT_DP]            = ~points[i];
        digit_byte[SEG_BIT_G:SEG_BIT_A]   = seg7[i];
      end
      text_vec[8*i +: 8] = digit_byte;
    end
    seg_vec = mode ? text_vec : raw_map;
  end

  // Output flops are loaded with the value for the state being entered, so
  // every output is registered yet lines up with the FSM state it belongs to.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    div_d      = div_q;
    bit_d      = bit_q;
    blink_d    = blink_q + 1'b1;
    seg_clk_d  = 1'b0;
    seg_sout_d = seg_sout_q;
    seg_pen_d  = seg_pen_q;
    clrn_d     = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_inc    = div_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          sr_d       = seg_vec;
          busy_d     = 1'b1;
          seg_pen_d  = 1'b0;
          seg_sout_d = 1'b1;
        end
      end

      ST_LOAD: begin
        state_d    = ST_SHIFT;
        div_d      = '0;
        bit_d      = '0;
        busy_d     = 1'b1;
        seg_pen_d  = 1'b0;
        seg_sout_d = sr_q[VEC_W-1];
        sr_d       = {sr_q[VEC_W-2:0], 1'b1};
      end

      ST_SHIFT: begin
        busy_d    = 1'b1;
        seg_pen_d = 1'b0;
        if (div_q == DIV_LAST) begin
          if (bit_q == BIT_LAST) begin
            state_d    = ST_LATCH;
            seg_sout_d = 1'b1;
            seg_pen_d  = 1'b1;
            done_d     = 1'b1;
          end else begin
            bit_d      = bit_q + 1'b1;
            div_d      = '0;
            seg_sout_d = sr_q[VEC_W-1];
            sr_d       = {sr_q[VEC_W-2:0], 1'b1};
          end
        end else begin
          div_d     = div_inc;
          seg_clk_d = (div_inc >= DIV_HIGH);
        end
      end

      ST_LATCH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '1;
      div_q      <= '0;
      bit_q      <= '0;
      blink_q    <= '0;
      seg_clk_q  <= 1'b0;
      seg_sout_q <= 1'b1;
      seg_pen_q  <= 1'b0;
      clrn_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      blink_q    <= blink_d;
      seg_clk_q  <= seg_clk_d;
      seg_sout_q <= seg_sout_d;
      seg_pen_q  <= seg_pen_d;
      clrn_q     <= clrn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_sout = seg_sout_q;
  assign seg_pen  = seg_pen_q;
  assign seg_clrn = clrn_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sseg_serial_driver.sv
// Directed bench for sseg_serial_driver: two 2-digit instances, CLK_DIV=1 (a)
// and CLK_DIV=2 (b), both with a 4-bit blink counter.
module tb_sseg_serial_driver;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [7:0]  hexs;
  logic [1:0]  points;
  logic [1:0]  les;
  logic [15:0] raw_map;
  logic        start_w    [2];
  logic        seg_clk_w  [2];
  logic        seg_sout_w [2];
  logic        seg_pen_w  [2];
  logic        seg_clrn_w [2];
  logic        busy_w     [2];
  logic        done_w     [2];

  sseg_serial_driver #(.NUM_DIGITS(2), .CLK_DIV(1), .BLINK_BITS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_w[0]), .mode(mode), .hexs(hexs),
    .points(points), .les(les), .raw_map(raw_map),
    .seg_clk(seg_clk_w[0]), .seg_sout(seg_sout_w[0]), .seg_pen(seg_pen_w[0]),
    .seg_clrn(seg_clrn_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  sseg_serial_driver #(.NUM_DIGITS(2), .CLK_DIV(2), .BLINK_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_w[1]), .mode(mode), .hexs(hexs),
    .points(points), .les(les), .raw_map(raw_map),
    .seg_clk(seg_clk_w[1]), .seg_sout(seg_sout_w[1]), .seg_pen(seg_pen_w[1]),
    .seg_clrn(seg_clrn_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance activity counters, sampled on the falling edge.
  int          rises    [2] = '{0, 0};
  int          busy_cyc [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          clk_hi   [2] = '{0, 0};
  int          pen_bad  [2] = '{0, 0};
  int          sout_bad [2] = '{0, 0};
  logic [15:0] bits     [2] = '{16'h0, 16'h0};
  logic        prev_clk [2] = '{1'b0, 1'b0};
  logic        prev_sout[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (seg_clk_w[i] === 1'b1 && prev_clk[i] === 1'b0) begin
        rises[i] = rises[i] + 1;
        bits[i]  = {bits[i][14:0], seg_sout_w[i]};
      end
      if (seg_clk_w[i] === 1'b1) clk_hi[i] = clk_hi[i] + 1;
      if (busy_w[i] === 1'b1) busy_cyc[i] = busy_cyc[i] + 1;
      if (done_w[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
      if (busy_w[i] === 1'b1 && done_w[i] !== 1'b1 && seg_pen_w[i] !== 1'b0)
        pen_bad[i] = pen_bad[i] + 1;
      if (done_w[i] === 1'b1 && (seg_pen_w[i] !== 1'b1 || busy_w[i] !== 1'b1))
        pen_bad[i] = pen_bad[i] + 1;
      if (seg_clk_w[i] === 1'b1 && seg_sout_w[i] !== prev_sout[i])
        sout_bad[i] = sout_bad[i] + 1;
      prev_clk[i]  = seg_clk_w[i];
      prev_sout[i] = seg_sout_w[i];
    end
  end

  // Reference blink counter (4 bits, cleared by rst, free-running otherwise).
  logic [3:0] bm;
  always @(posedge clk) begin
    if (rst) bm <= 4'h0;
    else     bm <= bm + 4'h1;
  end

  int checks = 0;
  int fails  = 0;
  int lat;
  bit timed_out;
  int s_rises, s_busy, s_done, s_hi, s_pen, s_sout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int d);
    s_rises = rises[d];
    s_busy  = busy_cyc[d];
    s_done  = done_cnt[d];
    s_hi    = clk_hi[d];
    s_pen   = pen_bad[d];
    s_sout  = sout_bad[d];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d, input bit hold);
    snap(d);
    start_w[d] = 1'b1;
    lat = 0;
    step();
    lat = 1;
    if (!hold) start_w[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (done_w[d] !== 1'b1 && n < 200) begin
      step();
      lat++;
      n++;
      @(negedge clk);
    end
    timed_out = (n >= 200);
    step();
  endtask

  task automatic verify(input int d, input string tag, input logic [15:0] exp_bits);
    int cd;
    cd = d + 1;
    check({tag, " timeout"}, 32'(timed_out), 32'd0);
    check({tag, " done latency"}, lat, 2 + 32 * cd);
    check({tag, " busy cycles"}, busy_cyc[d] - s_busy, 2 + 32 * cd);
    check({tag, " done pulses"}, done_cnt[d] - s_done, 1);
    check({tag, " seg_clk rises"}, rises[d] - s_rises, 16);
    check({tag, " seg_clk high cycles"}, clk_hi[d] - s_hi, 16 * cd);
    check({tag, " seg_pen phase"}, pen_bad[d] - s_pen, 0);
    check({tag, " sout stable while clk high"}, sout_bad[d] - s_sout, 0);
    check({tag, " shifted bits"}, 32'(bits[d]), 32'(exp_bits));
    check({tag, " seg_pen held in idle"}, 32'(seg_pen_w[d]), 32'd1);
    check({tag, " busy low in idle"}, 32'(busy_w[d]), 32'd0);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check({tag, " seg_clk"},  32'(seg_clk_w[d]),  32'd0);
    check({tag, " seg_sout"}, 32'(seg_sout_w[d]), 32'd1);
    check({tag, " seg_pen"},  32'(seg_pen_w[d]),  32'd0);
    check({tag, " seg_clrn"}, 32'(seg_clrn_w[d]), 32'd0);
    check({tag, " busy"},     32'(busy_w[d]),     32'd0);
    check({tag, " done"},     32'(done_w[d]),     32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset with arbitrary inputs, start requested on both instances.
    rst = 1'b1; mode = 1'b1; hexs = 8'h3C; points = 2'b10; les = 2'b11;
    raw_map = 16'h1234; start_w[0] = 1'b1; start_w[1] = 1'b1;
    repeat (3) step();
    check_reset_vals(0, "reset a");
    check_reset_vals(1, "reset b");
    rst = 1'b0; start_w[0] = 1'b0; start_w[1] = 1'b0;
    step();
    check("release a seg_clrn", 32'(seg_clrn_w[0]), 32'd1);
    check("release b seg_clrn", 32'(seg_clrn_w[1]), 32'd1);
    check("release a busy", 32'(busy_w[0]), 32'd0);

    // Text mode: digit1='8' dp off, digit0='0' dp on -> 80,40.
    mode = 1'b1; hexs = 8'h80; points = 2'b01; les = 2'b00;
    do_start(0, 1'b0);
    wait_done(0);
    verify(0, "text", 16'h8040);

    // Raw mode, raw_map changed mid-shift must not affect the transfer.
    mode = 1'b0; raw_map = 16'hA55A;
    do_start(1, 1'b0);
    repeat (10) begin step(); lat++; end
    raw_map = 16'h0000;
    wait_done(1);
    verify(1, "raw snapshot", 16'hA55A);

    // Blink: digit1 blink-enabled, both show '1' with dp off.
    mode = 1'b1; hexs = 8'h11; points = 2'b00; les = 2'b10;
    n = 0;
    while (bm[3] !== 1'b0 && n < 20) begin step(); n++; end
    do_start(0, 1'b0);
    wait_done(0);
    verify(0, "blink phase0", 16'hF9F9);
    n = 0;
    while (bm[3] !== 1'b1 && n < 20) begin step(); n++; end
    do_start(0, 1'b0);
    wait_done(0);
    verify(0, "blink phase1", 16'hFFF9);

    // start pulsed during SHIFT is ignored and not queued.
    hexs = 8'h80; points = 2'b01; les = 2'b00;
    do_start(0, 1'b0);
    repeat (5) begin step(); lat++; end
    start_w[0] = 1'b1;
    step(); lat++;
    start_w[0] = 1'b0;
    wait_done(0);
    verify(0, "start in shift", 16'h8040);
    snap(0);
    repeat (6) step();
    check("start in shift no requeue busy", busy_cyc[0] - s_busy, 0);
    check("start in shift no requeue done", done_cnt[0] - s_done, 0);

    // start held high: back-to-back refreshes with one IDLE cycle between.
    do_start(0, 1'b1);
    wait_done(0);
    verify(0, "held start first", 16'h8040);
    snap(0);
    lat = 0;
    step();
    lat = 1;
    check("held start second load busy", 32'(busy_w[0]), 32'd1);
    start_w[0] = 1'b0;
    wait_done(0);
    verify(0, "held start second", 16'h8040);
    snap(0);
    repeat (4) step();
    check("held start no third refresh", busy_cyc[0] - s_busy, 0);

    // Reset during SHIFT bit 5, then a clean refresh.
    hexs = 8'hA5; points = 2'b11;
    do_start(0, 1'b0);
    repeat (11) begin step(); lat++; end
    check("mid-shift still busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    step();
    check_reset_vals(0, "mid-shift reset");
    rst = 1'b0;
    step();
    check("mid-shift release seg_clrn", 32'(seg_clrn_w[0]), 32'd1);
    hexs = 8'h80; points = 2'b01;
    do_start(0, 1'b0);
    wait_done(0);
    verify(0, "after reset", 16'h8040);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
